// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types, CRC constants and sizing helper for the chain loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Bits taken from the final word; a short tail keeps only its top bits.
  function automatic int last_word_bits(input int chain_len, input int word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream word handshake between feeder and chain loader
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
) ();

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16-CCITT, MSB-first (used under CCFF_LOADER_CRC_EN)
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ din_i;
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words MSB-first into a prog_clk configuration chain
// Optional crc16 output over the shifted bits when CCFF_LOADER_CRC_EN is defined.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset_n,
  input  logic                 start,
  ccff_chain_loader_if.slave   wr,
  output logic                 ccff_head,
  output logic                 ccff_clk_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bits_left
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic [15:0]          crc16
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  localparam int               WC_W      = $clog2(WORD_W + 1);
  localparam logic [WC_W-1:0]  WORD_CNT  = WC_W'(WORD_W);
  localparam logic [WC_W-1:0]  LAST_CNT  = WC_W'(last_word_bits(CHAIN_LEN, WORD_W));
  localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);

  logic [1:0]        state_q,     state_d;
  logic [WORD_W-1:0] sr_q,        sr_d;
  logic [WC_W-1:0]   wcnt_q,      wcnt_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic              head_q,      head_d;
  logic              clk_en_q,    clk_en_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    wcnt_d      = wcnt_q;
    bits_left_d = bits_left_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bits_left_d = CHAIN_CNT;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (wr.word_valid) begin
          sr_d    = wr.word_data;
          // Only the final word can hold fewer than WORD_W remaining bits.
          wcnt_d  = (int'(bits_left_q) <= WORD_W) ? LAST_CNT : WORD_CNT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        head_d      = sr_q[WORD_W-1];
        clk_en_d    = 1'b1;
        sr_d        = {sr_q[WORD_W-2:0], 1'b0};
        bits_left_d = bits_left_q - CNT_W'(1);
        wcnt_d      = wcnt_q - WC_W'(1);
        if (bits_left_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (wcnt_q == WC_W'(1)) begin
          state_d = FETCH;
        end
      end
      DONE: begin
        // busy is still set on the first DONE cycle, so done pulses exactly once.
        done_d = busy_q;
        busy_d = 1'b0;
        if (start) begin
          bits_left_d = CHAIN_CNT;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      wcnt_q      <= '0;
      bits_left_q <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      wcnt_q      <= wcnt_d;
      bits_left_q <= bits_left_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr.word_ready = (state_q == FETCH);
  assign ccff_head     = head_q;
  assign ccff_clk_en   = clk_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bits_left     = bits_left_q;

`ifdef CCFF_LOADER_CRC_EN
  logic crc_init;
  logic crc_en;

  assign crc_init = start && ((state_q == IDLE) || (state_q == DONE));
  assign crc_en   = (state_q == SHIFT);

  ccff_crc16_serial u_crc (
    .clk_i  (prog_clk),
    .rst_ni (prog_reset_n),
    .init_i (crc_init),
    .en_i   (crc_en),
    .din_i  (sr_q[WORD_W-1]),
    .crc_o  (crc16)
  );
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader, WORD_W=8 CHAIN_LEN=20
module tb_ccff_chain_loader;

  logic       prog_clk;
  logic       prog_reset_n;
  logic       start;
  logic       ccff_head;
  logic       ccff_clk_en;
  logic       busy;
  logic       done;
  logic [4:0] bits_left;
`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] crc16;
`endif

  ccff_chain_loader_if #(.WORD_W(8)) wr_if ();

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .wr           (wr_if),
    .ccff_head    (ccff_head),
    .ccff_clk_en  (ccff_clk_en),
    .busy         (busy),
    .done         (done),
    .bits_left    (bits_left)
`ifdef CCFF_LOADER_CRC_EN
    ,
    .crc16        (crc16)
`endif
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          cyc_start = 0;
  int          cyc_done = 0;
  int          en_cnt = 0;
  int          en_first = -1;
  int          done_cnt = 0;
  logic [19:0] chain = '0;
  logic        exp_q[$];

  localparam logic [19:0] EXP_CHAIN = 20'hA53CF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [19:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 19; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always @(posedge prog_clk) cyc++;

  // Chain model and scoreboard: each enabled cycle's head bit is what the chain captures.
  always @(negedge prog_clk) begin
    if (prog_reset_n === 1'b1 && ccff_clk_en === 1'b1) begin
      if (en_cnt == 0) en_first = cyc;
      en_cnt++;
      chain = {chain[18:0], ccff_head};
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("head_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
    end
    if (done === 1'b1) begin
      done_cnt++;
      cyc_done = cyc;
    end
  end

  task automatic start_load();
    en_cnt   = 0;
    done_cnt = 0;
    en_first = -1;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    cyc_start = cyc;
  endtask

  task automatic push_bits(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) exp_q.push_back(w[i]);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    int n;
    n = 0;
    push_bits(w, nbits);
    wr_if.word_data  = w;
    wr_if.word_valid = 1'b1;
    while (wr_if.word_ready !== 1'b1 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("fetch_ready", 32'(wr_if.word_ready), 32'd1);
    @(posedge prog_clk); #1;
  endtask

  task automatic wait_bits(input int v);
    int n;
    n = 0;
    do begin
      @(negedge prog_clk);
      n++;
    end while (bits_left !== 5'(v) && n < 200);
    chk("bits_left_reach", 32'(bits_left), 32'(v));
  endtask

  task automatic finish_load(input int exp_lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    repeat (3) @(negedge prog_clk);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("en_count", 32'(en_cnt), 32'd20);
    chk("bits_left_end", 32'(bits_left), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("chain_bits", 32'(chain), 32'(EXP_CHAIN));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("done_latency", 32'(cyc_done - cyc_start), 32'(exp_lat));
  endtask

  initial begin
    prog_reset_n     = 1'b0;
    start            = 1'b0;
    wr_if.word_data  = '0;
    wr_if.word_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("rst_head", 32'(ccff_head), 32'd0);
    chk("rst_clk_en", 32'(ccff_clk_en), 32'd0);
    chk("rst_ready", 32'(wr_if.word_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bits_left", 32'(bits_left), 32'd0);
`ifdef CCFF_LOADER_CRC_EN
    chk("rst_crc", 32'(crc16), 32'h0000FFFF);
`endif
    @(negedge prog_clk) prog_reset_n = 1'b1;

    // Straight load from IDLE, valid held high throughout.
    start_load();
    chk("busy_after_start", 32'(busy), 32'd1);
    send_word(8'hA5, 8);
    send_word(8'h3C, 8);
    send_word(8'hF0, 4);
    wr_if.word_data = 8'h55;
    finish_load(24);
    chk("first_en_latency", 32'(en_first - cyc_start), 32'd2);
    chk("ready_after_done", 32'(wr_if.word_ready), 32'd0);
`ifdef CCFF_LOADER_CRC_EN
    chk("crc_final", 32'(crc16), 32'(crc_ref(EXP_CHAIN)));
`endif
    wr_if.word_valid = 1'b0;

    // Restart from DONE with a 5-cycle valid gap before the second word.
    start_load();
`ifdef CCFF_LOADER_CRC_EN
    chk("crc_reinit", 32'(crc16), 32'h0000FFFF);
`endif
    send_word(8'hA5, 8);
    wr_if.word_valid = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge prog_clk);
        n++;
      end while (wr_if.word_ready !== 1'b1 && n < 50);
      chk("gap_fetch", 32'(wr_if.word_ready), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      chk("gap_en_low", 32'(ccff_clk_en), 32'd0);
    end
    send_word(8'h3C, 8);
    send_word(8'hF0, 4);
    wr_if.word_valid = 1'b0;
    finish_load(29);

    // start pulsed mid-load is ignored.
    start_load();
    send_word(8'hA5, 8);
    push_bits(8'h3C, 8);
    wr_if.word_data = 8'h3C;
    wait_bits(12);
    start = 1'b1;
    @(negedge prog_clk) start = 1'b0;
    chk("midstart_bits_left", 32'(bits_left), 32'd12);
    chk("midstart_busy", 32'(busy), 32'd1);
    send_word(8'hF0, 4);
    wr_if.word_valid = 1'b0;
    finish_load(24);

    // Asynchronous reset mid-load, then a full load from IDLE.
    start_load();
    send_word(8'hA5, 8);
    send_word(8'h3C, 8);
    wait_bits(7);
    prog_reset_n     = 1'b0;
    wr_if.word_valid = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clk_en", 32'(ccff_clk_en), 32'd0);
    chk("arst_ready", 32'(wr_if.word_ready), 32'd0);
    chk("arst_bits_left", 32'(bits_left), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge prog_clk) prog_reset_n = 1'b1;
    start_load();
    send_word(8'hA5, 8);
    send_word(8'h3C, 8);
    send_word(8'hF0, 4);
    wr_if.word_valid = 1'b0;
    finish_load(24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream feeder for the configuration-chain memories (serial DFF shift chains clocked by prog_clk, entered through ccff_head, exited through ccff_tail).
- Accepts parallel bitstream words over a valid/ready handshake and serializes them MSB-first onto ccff_head.
- Drives a clock-enable for the external prog_clk gate, so the chain advances exactly once per delivered bit.
- Stops after exactly CHAIN_LEN bits and signals completion.

Parameters:
- WORD_W, 32: bitstream word width. Must be at least 2.
- CHAIN_LEN, 1024: total configuration bits in the chain. Must be at least 1.
- CNT_W, $clog2(CHAIN_LEN+1): bit-counter width. Derived; not to be overridden.

Ports:
- prog_clk  input  1  programming clock; all state is on its rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load. Ignored unless the block is in IDLE or DONE.
- word_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  block accepts the word this cycle.
- ccff_head  output  1  serial data to the chain head. Registered.
- ccff_clk_en  output  1  enable to the external prog_clk gate. Registered.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the final bit has been shifted.
- bits_left  output  CNT_W  bits still to be shifted.

Behaviour:
- Interface (decided): single clock prog_clk; reset prog_reset_n is asynchronous, active-low.
- Reset values: ccff_head=0, ccff_clk_en=0, word_ready=0, busy=0, done=0, bits_left=0, state=IDLE.
- Chain edge rule: the gated chain clock fires on the prog_clk edge that ends a cycle with ccff_clk_en=1. That edge samples the ccff_head value present during the cycle. ccff_head and ccff_clk_en are updated together from the same registers.
- State machine:
  - IDLE: on start, bits_left<=CHAIN_LEN, busy<=1, go to FETCH.
  - FETCH: word_ready=1 (combinational from state). On word_valid, load the shift register with word_data, set the per-word bit counter to min(WORD_W, bits_left), go to SHIFT. Without word_valid: stall with ccff_clk_en=0; the chain holds.
  - SHIFT: each cycle, present the shift-register MSB on ccff_head with ccff_clk_en=1, shift left, decrement bits_left and the word counter.
    - Word counter reaches 0 and bits_left>0: go to FETCH. This costs one bubble cycle with ccff_clk_en=0.
    - bits_left reaches 0: go to DONE.
  - DONE: ccff_clk_en<=0, done pulses for 1 cycle, busy<=0. start restarts the load (go to FETCH with bits_left reloaded). Otherwise hold DONE.
- Partial last word: when CHAIN_LEN mod WORD_W ≠ 0, only the top (CHAIN_LEN mod WORD_W) bits of the last word are shifted. The remaining low bits are discarded.
- Words presented after the last one are not accepted; word_ready stays 0 outside FETCH.
- start while busy: ignored.
- Reset mid-load: all outputs return to reset values immediately. Chain contents are undefined, and software must reload from IDLE.
- Latency:
  - First ccff_clk_en=1 occurs 2 cycles after start when word_valid is already high.
  - Minimum total is CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from start to done.

Optional Feature:
- Macro: CCFF_LOADER_CRC_EN.
- Defined: adds output crc16 [15:0]. It is a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) updated with ccff_head on every cycle with ccff_clk_en=1.
  - Re-initialized on start.
  - Stable and valid from the done pulse until the next start.
  - Reset value 0xFFFF.
- Undefined: no crc16 port and no CRC logic.

Decomposition:
- Shared package ccff_loader_pkg:
  - state enum (IDLE, FETCH, SHIFT, DONE);
  - CRC polynomial and init constants;
  - a function computing the last-word bit count from CHAIN_LEN and WORD_W.
- One sub-module: ccff_crc16_serial (1-bit-per-cycle CRC with enable and init). Instantiated only under CCFF_LOADER_CRC_EN.

Test Plan (WORD_W=8, CHAIN_LEN=20):
- Reset, start, words 0xA5, 0x3C, 0xF0 held valid → ccff_head sequence on enabled cycles: 10100101 00111100 1111. Exactly 20 ccff_clk_en=1 cycles. The low nibble of 0xF0 is never shifted. done pulses once, bits_left=0, and a 20-DFF chain model holds the expected bits.
- Same words, but word_valid dropped for 5 cycles before the second word → ccff_clk_en=0 for those cycles. Chain model contents are identical to the first test, and done is 5 cycles later.
- start pulsed again mid-load (bits_left=12) → ignored. bits_left continues to decrement; one done only.
- prog_reset_n asserted with bits_left=7 → same cycle: busy=0, ccff_clk_en=0, word_ready=0, bits_left=0. A subsequent start performs a full 20-bit load.
- Start after done → second load accepted and completes.
- With CCFF_LOADER_CRC_EN: load as in the first test → crc16 equals the reference-model CRC of the 20 shifted bits. crc16 reads 0xFFFF after a following start.
